// File: rtl/div_if.sv
// Operand/result handshake between the execute stage and the divider.
interface div_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;

    modport master (output start, op, a, b, input busy, done, result);
    modport slave  (input start, op, a, b, output busy, done, result);
endinterface

// File: rtl/div_unit.sv
// Iterative restoring divider for DIV/DIVU/REM/REMU, one quotient bit per clock.
// Latency is fixed at WIDTH+1 cycles from the start edge to the done pulse.
module div_unit #(
    parameter int WIDTH = 32
) (
    input logic  clk,
    input logic  rst,
    div_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

    state_t           state;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] abs_b;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [CNT_W-1:0] count;
    logic             q_neg;
    logic             r_neg;
    logic             div0;
    logic             ovf;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] result_q;

    // Capture-time decode, one shift-subtract step, and final result selection.
    logic             in_signed;
    logic [WIDTH-1:0] in_abs_a;
    logic [WIDTH-1:0] in_abs_b;
    logic             in_ovf;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quo_next;
    logic [WIDTH-1:0] fin_result;

    // Operand decode, restoring step and result mux; all purely combinational.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        in_signed  = ~bus.op[0];
        in_abs_a   = (in_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
        in_abs_b   = (in_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;
        in_ovf     = in_signed && (bus.a == {1'b1, {(WIDTH-1){1'b0}}}) && (&bus.b);

        // Shift {rem,quo} left; the bit leaving quo enters rem at WIDTH+1 bits.
        rem_sh     = {rem, quo[WIDTH-1]};
        trial      = rem_sh - {1'b0, abs_b};
        quo_next   = {quo[WIDTH-2:0], ~trial[WIDTH]};
        rem_next   = trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];

        fin_result = '0;
        if (div0) begin
            fin_result = op_q[1] ? a_q : '1;
        end else if (ovf) begin
            fin_result = op_q[1] ? '0 : {1'b1, {(WIDTH-1){1'b0}}};
        end else if (op_q[1]) begin
            fin_result = (r_neg && !op_q[0]) ? -rem : rem;
        end else begin
            fin_result = (q_neg && !op_q[0]) ? -quo : quo;
        end
    end

    // Control FSM and datapath registers; outputs are registered here too.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
        if (rst) begin
            // NOTE: every register, datapath included, is cleared so reset leaves no stale operation behind.
            state    <= IDLE;
            op_q     <= '0;
            a_q      <= '0;
            abs_b    <= '0;
            rem      <= '0;
            quo      <= '0;
            count    <= '0;
            q_neg    <= 1'b0;
            r_neg    <= 1'b0;
            div0     <= 1'b0;
            ovf      <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        op_q   <= bus.op;
                        a_q    <= bus.a;
                        abs_b  <= in_abs_b;
                        rem    <= '0;
                        quo    <= in_abs_a;
                        count  <= CNT_W'(WIDTH);
                        q_neg  <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
                        r_neg  <= bus.a[WIDTH-1];
                        div0   <= (bus.b == '0);
                        ovf    <= in_ovf;
                        busy_q <= 1'b1;
                        state  <= CALC;
                    end
                end
                CALC: begin
                    rem   <= rem_next;
                    quo   <= quo_next;
                    count <= count - 1'b1;
                    if (count == CNT_W'(1)) begin
                        state <= FIN;
                    end
                end
                FIN: begin
                    result_q <= fin_result;
                    done_q   <= 1'b1;
                    busy_q   <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Iterative restoring divider for the RV32M divide group: DIV, DIVU, REM, REMU.
- Sits beside the ALU in the execute stage. It performs division by repeated shift-and-subtract, reusing the adder/subtractor datapath one bit per clock.
- Operands are taken through a start/busy/done handshake. Latency is fixed, so the pipeline can stall deterministically while it runs.

Parameters:
WIDTH, 32, operand and result width in bits (must be >= 2)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
start  input  1  request; sampled only in IDLE
op  input  2  00=DIV, 01=DIVU, 10=REM, 11=REMU; captured with start
a  input  WIDTH  dividend; captured with start
b  input  WIDTH  divisor; captured with start
busy  output  1  high while an operation is in flight
done  output  1  one-cycle pulse; result valid
result  output  WIDTH  quotient or remainder, held until next done

Behaviour:
Reset:
- rst high at a rising edge: state=IDLE, busy=0, done=0, result=0, all internal registers cleared.
- Applies mid-operation; the in-flight operation is discarded with no done.

States and transitions:
- IDLE -> CALC when start=1 at edge N.
  - Captures op, a, b, and absolute values for signed ops (|a|, |b|, where |0x80000000| = 0x80000000 unsigned).
  - Captures sign flags: quotient negative = sign(a) XOR sign(b); remainder negative = sign(a).
  - Captures special-case flags: div0 = (b==0); ovf = signed op, a=0x80..0, b=all ones.
  - Clears remainder register, loads quotient register with |a|, sets count=WIDTH.
- CALC, edges N+1 .. N+WIDTH, one iteration per edge:
  - shift {rem,quo} left 1;
  - trial = rem_shifted - |b| computed at WIDTH+1 bits;
  - if trial is non-negative, rem = trial and quo LSB = 1, else quo LSB = 0;
  - count decrements; leave to FIN when count reaches 1 on this edge.
- FIN at edge N+WIDTH+1: result register loaded, done=1, busy=0, state -> IDLE. Result selection:
  - div0: DIV/DIVU -> all ones; REM/REMU -> a (original).
  - ovf: DIV -> 0x80..0; REM -> 0.
  - otherwise: quotient or remainder, two's-complement negated if the corresponding sign flag is set and the op is signed.

Handshake and timing:
- busy=1 for edges N+1 .. N+WIDTH+1 outputs.
- done is high for exactly one cycle, WIDTH+1 cycles after the start edge (33 for WIDTH=32).
- Latency is identical for all ops, including div0 and ovf.
- start while busy is ignored; op/a/b changes while busy have no effect.
- start may be asserted in the same cycle done is high (state is IDLE); it is accepted, giving back-to-back operation.
- result changes only on the FIN edge or on reset.

Arithmetic:
- All internal subtraction is unsigned at WIDTH+1 bits; no overflow is possible.
- Negation is modulo 2^WIDTH.
- Quotient truncates toward zero; the remainder takes the sign of the dividend.

Test Plan:
- DIVU a=100, b=7 -> done exactly 33 cycles after start edge, result=14; REMU same operands -> result=2; busy high throughout, low with done.
- DIV a=0xFFFFFFF9 (-7), b=2 -> result=0xFFFFFFFD (-3); REM same -> 0xFFFFFFFF (-1); REM a=7, b=0xFFFFFFFE -> 1.
- Divide by zero: DIVU 5/0 -> 0xFFFFFFFF, DIV 5/0 -> 0xFFFFFFFF, REM 5/0 -> 5, REMU 0xDEADBEEF/0 -> 0xDEADBEEF; latency still 33.
- Overflow: DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM same -> 0. DIVU 0x80000000 / 0xFFFFFFFF -> 0 (not special).
- Handshake: start pulsed again at cycle 10 of a DIVU 100/7 with a=1, b=1 -> ignored, result=14. start held high on the done cycle with DIVU 9/3 -> second done 33 cycles later, result=3.
- Reset at cycle 15 of an operation -> next cycle busy=0, done=0, result=0, and no done pulse follows. A new DIVU 50/5 issued afterwards -> result=10.
